// File: rtl/except_ctrl.sv
// except_ctrl: MEM-stage exception/ERET arbiter. Picks the highest-priority
// condition on the MEM instruction, reports it to CP0 for one cycle, flushes
// IF..MEM and holds a fetch redirect until the fetch unit accepts it.
module except_ctrl #(
  parameter logic [31:0] VEC_BEV  = 32'hBFC0_0380,
  parameter logic [31:0] VEC_NORM = 32'h8000_0180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic        mem_bd,
  input  logic [7:0]  mem_flags,
  input  logic [31:0] mem_daddr,
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_cause,
  input  logic [31:0] cp0_epc,
  output logic        exc_valid,
  output logic        exc_eret,
  output logic [4:0]  exc_code,
  output logic [31:0] exc_pc,
  output logic        exc_bd,
  output logic [31:0] exc_badvaddr,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t      state_q;
  logic        exc_valid_q;
  logic        exc_eret_q;
  logic [4:0]  exc_code_q;
  logic [31:0] exc_pc_q;
  logic        exc_bd_q;
  logic [31:0] exc_badvaddr_q;
  logic        flush_q;
  logic        redirect_valid_q;
  logic [31:0] redirect_pc_q;

  logic        int_p;
  logic        detect;
  logic        take_eret_d;
  logic [4:0]  exc_code_d;
  logic [31:0] exc_badvaddr_d;
  logic [31:0] exc_pc_d;
  logic [31:0] redirect_pc_d;

  // CP0 register bits this block does not look at.
  logic unused_cp0_bits;
  assign unused_cp0_bits = &{1'b0, cp0_status[31:23], cp0_status[21:16],
                             cp0_status[7:2], cp0_cause[31:16], cp0_cause[7:0]};

  // Priority encoder: interrupt first, then the per-instruction flags in
  // pipeline order; ERET only wins when nothing else is pending.
  always_comb begin
    int_p          = cp0_status[0] & ~cp0_status[1] &
                     (|(cp0_cause[15:8] & cp0_status[15:8]));
    detect         = (state_q == IDLE) & mem_valid & (int_p | (|mem_flags));
    take_eret_d    = 1'b0;
    exc_code_d     = 5'h00;
    exc_badvaddr_d = 32'h0;
    if (int_p) begin
      exc_code_d = 5'h00;
    end else if (mem_flags[0]) begin
      exc_code_d     = 5'h04;
      exc_badvaddr_d = mem_pc;
    end else if (mem_flags[1]) begin
      exc_code_d = 5'h0A;
    end else if (mem_flags[2]) begin
      exc_code_d = 5'h0C;
    end else if (mem_flags[3]) begin
      exc_code_d = 5'h08;
    end else if (mem_flags[4]) begin
      exc_code_d = 5'h09;
    end else if (mem_flags[5]) begin
      exc_code_d     = 5'h04;
      exc_badvaddr_d = mem_daddr;
    end else if (mem_flags[6]) begin
      exc_code_d     = 5'h05;
      exc_badvaddr_d = mem_daddr;
    end else begin
      take_eret_d = 1'b1;
    end
    // A delay-slot instruction restarts at its branch, one word back.
    exc_pc_d = mem_bd ? (mem_pc - 32'd4) : mem_pc;
    if (take_eret_d) begin
      redirect_pc_d = cp0_epc;
    end else begin
      redirect_pc_d = cp0_status[22] ? VEC_BEV : VEC_NORM;
    end
  end

  // FSM and registered outputs: pulses last one cycle, the redirect is held
  // in WAIT until the fetch side handshakes, exception info is sticky.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q          <= IDLE;
      exc_valid_q      <= 1'b0;
      exc_eret_q       <= 1'b0;
      exc_code_q       <= 5'h00;
      exc_pc_q         <= 32'h0;
      exc_bd_q         <= 1'b0;
      exc_badvaddr_q   <= 32'h0;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'h0;
    end else begin
      exc_valid_q <= 1'b0;
      exc_eret_q  <= 1'b0;
      flush_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (detect) begin
            state_q          <= WAIT;
            flush_q          <= 1'b1;
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= redirect_pc_d;
            if (take_eret_d) begin
              exc_eret_q <= 1'b1;
            end else begin
              exc_valid_q    <= 1'b1;
              exc_code_q     <= exc_code_d;
              exc_pc_q       <= exc_pc_d;
              exc_bd_q       <= mem_bd;
              exc_badvaddr_q <= exc_badvaddr_d;
            end
          end
        end
        WAIT: begin
          if (redirect_valid_q && redirect_ready) begin
            state_q          <= IDLE;
            redirect_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign exc_valid      = exc_valid_q;
  assign exc_eret       = exc_eret_q;
  assign exc_code       = exc_code_q;
  assign exc_pc         = exc_pc_q;
  assign exc_bd         = exc_bd_q;
  assign exc_badvaddr   = exc_badvaddr_q;
  assign flush          = flush_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_except_ctrl.sv
// tb_except_ctrl: directed checks of except_ctrl priority, timing, WAIT
// hold behaviour and reset, with hand-computed expected values.
module tb_except_ctrl;

  logic        clk;
  logic        rst;
  logic        mem_valid;
  logic [31:0] mem_pc;
  logic        mem_bd;
  logic [7:0]  mem_flags;
  logic [31:0] mem_daddr;
  logic [31:0] cp0_status;
  logic [31:0] cp0_cause;
  logic [31:0] cp0_epc;
  logic        exc_valid;
  logic        exc_eret;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic [31:0] exc_badvaddr;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  int checks;
  int failures;

  except_ctrl dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_bd(mem_bd),
    .mem_flags(mem_flags), .mem_daddr(mem_daddr), .cp0_status(cp0_status),
    .cp0_cause(cp0_cause), .cp0_epc(cp0_epc), .exc_valid(exc_valid),
    .exc_eret(exc_eret), .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd),
    .exc_badvaddr(exc_badvaddr), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .redirect_ready(redirect_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept the pending redirect and leave the pipeline idle.
  task automatic release_redirect();
    mem_valid      = 1'b0;
    redirect_ready = 1'b1;
    step();
    redirect_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    checks++; if (exc_valid !== 1'b0) begin failures++; $display("FAIL reset_exc_valid got=%h exp=0", exc_valid); end
    checks++; if (exc_eret !== 1'b0) begin failures++; $display("FAIL reset_exc_eret got=%h exp=0", exc_eret); end
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL reset_flush got=%h exp=0", flush); end
    checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL reset_redirect_valid got=%h exp=0", redirect_valid); end
    checks++; if (redirect_pc !== 32'h0) begin failures++; $display("FAIL reset_redirect_pc got=%h exp=0", redirect_pc); end
    checks++; if (exc_code !== 5'h0) begin failures++; $display("FAIL reset_exc_code got=%h exp=0", exc_code); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_ri_bev();
    cp0_status = 32'h0040_0000;
    mem_valid  = 1'b1;
    mem_flags  = 8'h02;
    mem_pc     = 32'h8000_1000;
    mem_bd     = 1'b0;
    step();
    checks++; if (exc_valid !== 1'b1) begin failures++; $display("FAIL ri_exc_valid got=%h exp=1", exc_valid); end
    checks++; if (exc_code !== 5'h0A) begin failures++; $display("FAIL ri_exc_code got=%h exp=0a", exc_code); end
    checks++; if (exc_pc !== 32'h8000_1000) begin failures++; $display("FAIL ri_exc_pc got=%h exp=80001000", exc_pc); end
    checks++; if (exc_bd !== 1'b0) begin failures++; $display("FAIL ri_exc_bd got=%h exp=0", exc_bd); end
    checks++; if (exc_badvaddr !== 32'h0) begin failures++; $display("FAIL ri_badvaddr got=%h exp=0", exc_badvaddr); end
    checks++; if (redirect_pc !== 32'hBFC0_0380) begin failures++; $display("FAIL ri_redirect_pc got=%h exp=bfc00380", redirect_pc); end
    checks++; if (flush !== 1'b1) begin failures++; $display("FAIL ri_flush got=%h exp=1", flush); end
    checks++; if (redirect_valid !== 1'b1) begin failures++; $display("FAIL ri_redirect_valid got=%h exp=1", redirect_valid); end
    mem_valid = 1'b0;
    step();
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL ri_flush_pulse got=%h exp=0", flush); end
    checks++; if (exc_valid !== 1'b0) begin failures++; $display("FAIL ri_valid_pulse got=%h exp=0", exc_valid); end
    checks++; if (redirect_valid !== 1'b1) begin failures++; $display("FAIL ri_redirect_held got=%h exp=1", redirect_valid); end
    release_redirect();
    checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL ri_redirect_release got=%h exp=0", redirect_valid); end
  endtask

  task automatic test_load_adel_bd();
    cp0_status = 32'h0;
    mem_valid  = 1'b1;
    mem_flags  = 8'h20;
    mem_daddr  = 32'h0000_1235;
    mem_bd     = 1'b1;
    mem_pc     = 32'h8000_2004;
    step();
    checks++; if (exc_code !== 5'h04) begin failures++; $display("FAIL ladel_exc_code got=%h exp=04", exc_code); end
    checks++; if (exc_badvaddr !== 32'h0000_1235) begin failures++; $display("FAIL ladel_badvaddr got=%h exp=00001235", exc_badvaddr); end
    checks++; if (exc_pc !== 32'h8000_2000) begin failures++; $display("FAIL ladel_exc_pc got=%h exp=80002000", exc_pc); end
    checks++; if (exc_bd !== 1'b1) begin failures++; $display("FAIL ladel_exc_bd got=%h exp=1", exc_bd); end
    checks++; if (redirect_pc !== 32'h8000_0180) begin failures++; $display("FAIL ladel_redirect_pc got=%h exp=80000180", redirect_pc); end
    release_redirect();
  endtask

  task automatic test_fetch_adel_wrap();
    mem_valid = 1'b1;
    mem_flags = 8'h21;
    mem_daddr = 32'h0000_5555;
    mem_bd    = 1'b1;
    mem_pc    = 32'h0000_0000;
    step();
    checks++; if (exc_code !== 5'h04) begin failures++; $display("FAIL fadel_exc_code got=%h exp=04", exc_code); end
    checks++; if (exc_badvaddr !== 32'h0000_0000) begin failures++; $display("FAIL fadel_badvaddr got=%h exp=00000000", exc_badvaddr); end
    checks++; if (exc_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL fadel_exc_pc_wrap got=%h exp=fffffffc", exc_pc); end
    release_redirect();
  endtask

  task automatic test_priority();
    logic [7:0]  flagVec [4] = '{8'h06, 8'h18, 8'h50, 8'h40};
    logic [4:0]  codeExp [4] = '{5'h0A, 5'h08, 5'h09, 5'h05};
    logic [31:0] badvExp [4] = '{32'h0, 32'h0, 32'h0, 32'h0000_7778};
    mem_bd    = 1'b0;
    mem_daddr = 32'h0000_7778;
    for (int i = 0; i < 4; i++) begin
      mem_valid = 1'b1;
      mem_flags = flagVec[i];
      mem_pc    = 32'h8000_4000 + 32'(i * 4);
      step();
      checks++; if (exc_code !== codeExp[i]) begin failures++; $display("FAIL prio_code[%0d] got=%h exp=%h", i, exc_code, codeExp[i]); end
      checks++; if (exc_badvaddr !== badvExp[i]) begin failures++; $display("FAIL prio_badv[%0d] got=%h exp=%h", i, exc_badvaddr, badvExp[i]); end
      release_redirect();
    end
  endtask

  task automatic test_interrupt_eret();
    cp0_status = 32'h0000_8001;
    cp0_cause  = 32'h0000_8000;
    cp0_epc    = 32'h8000_4444;
    mem_valid  = 1'b1;
    mem_flags  = 8'h80;
    mem_pc     = 32'h8000_5000;
    mem_bd     = 1'b0;
    step();
    checks++; if (exc_valid !== 1'b1) begin failures++; $display("FAIL int_exc_valid got=%h exp=1", exc_valid); end
    checks++; if (exc_code !== 5'h00) begin failures++; $display("FAIL int_exc_code got=%h exp=00", exc_code); end
    checks++; if (exc_eret !== 1'b0) begin failures++; $display("FAIL int_exc_eret got=%h exp=0", exc_eret); end
    checks++; if (redirect_pc !== 32'h8000_0180) begin failures++; $display("FAIL int_redirect_pc got=%h exp=80000180", redirect_pc); end
    release_redirect();
    cp0_status = 32'h0000_8003;
    mem_valid  = 1'b1;
    step();
    checks++; if (exc_eret !== 1'b1) begin failures++; $display("FAIL eret_exc_eret got=%h exp=1", exc_eret); end
    checks++; if (exc_valid !== 1'b0) begin failures++; $display("FAIL eret_exc_valid got=%h exp=0", exc_valid); end
    checks++; if (flush !== 1'b1) begin failures++; $display("FAIL eret_flush got=%h exp=1", flush); end
    checks++; if (redirect_pc !== 32'h8000_4444) begin failures++; $display("FAIL eret_redirect_pc got=%h exp=80004444", redirect_pc); end
    mem_valid = 1'b0;
    step();
    checks++; if (exc_eret !== 1'b0) begin failures++; $display("FAIL eret_pulse got=%h exp=0", exc_eret); end
    release_redirect();
  endtask

  task automatic test_mem_valid_low();
    cp0_status = 32'h0000_8001;
    cp0_cause  = 32'h0000_8000;
    mem_valid  = 1'b0;
    mem_flags  = 8'hFF;
    step();
    checks++; if (exc_valid !== 1'b0) begin failures++; $display("FAIL nomv_exc_valid got=%h exp=0", exc_valid); end
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL nomv_flush got=%h exp=0", flush); end
    checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL nomv_redirect_valid got=%h exp=0", redirect_valid); end
    cp0_status = 32'h0;
    cp0_cause  = 32'h0;
  endtask

  task automatic test_ready_idle();
    mem_valid      = 1'b0;
    redirect_ready = 1'b1;
    step();
    redirect_ready = 1'b0;
    checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL rdyidle_redirect_valid got=%h exp=0", redirect_valid); end
    mem_valid = 1'b1;
    mem_flags = 8'h04;
    mem_pc    = 32'h8000_6000;
    step();
    checks++; if (exc_code !== 5'h0C) begin failures++; $display("FAIL rdyidle_exc_code got=%h exp=0c", exc_code); end
    release_redirect();
  endtask

  task automatic test_back_to_back();
    cp0_status = 32'h0040_0000;
    mem_valid  = 1'b1;
    mem_flags  = 8'h02;
    mem_pc     = 32'h8000_1000;
    mem_bd     = 1'b0;
    step();
    checks++; if (exc_valid !== 1'b1) begin failures++; $display("FAIL b2b_first_valid got=%h exp=1", exc_valid); end
    cp0_status = 32'h0;
    for (int i = 0; i < 5; i++) begin
      mem_valid = 1'b1;
      mem_flags = 8'h08;
      mem_pc    = 32'h8000_3000 + 32'(i * 4);
      step();
      checks++; if (exc_valid !== 1'b0) begin failures++; $display("FAIL b2b_hold_valid[%0d] got=%h exp=0", i, exc_valid); end
      checks++; if (redirect_valid !== 1'b1) begin failures++; $display("FAIL b2b_hold_rv[%0d] got=%h exp=1", i, redirect_valid); end
      checks++; if (redirect_pc !== 32'hBFC0_0380) begin failures++; $display("FAIL b2b_hold_rpc[%0d] got=%h exp=bfc00380", i, redirect_pc); end
      checks++; if (exc_code !== 5'h0A) begin failures++; $display("FAIL b2b_hold_code[%0d] got=%h exp=0a", i, exc_code); end
    end
    redirect_ready = 1'b1;
    step();
    redirect_ready = 1'b0;
    checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL b2b_handshake_rv got=%h exp=0", redirect_valid); end
    checks++; if (exc_valid !== 1'b0) begin failures++; $display("FAIL b2b_handshake_valid got=%h exp=0", exc_valid); end
    step();
    checks++; if (exc_valid !== 1'b1) begin failures++; $display("FAIL b2b_next_valid got=%h exp=1", exc_valid); end
    checks++; if (exc_code !== 5'h08) begin failures++; $display("FAIL b2b_next_code got=%h exp=08", exc_code); end
    checks++; if (exc_pc !== 32'h8000_3010) begin failures++; $display("FAIL b2b_next_pc got=%h exp=80003010", exc_pc); end
    checks++; if (redirect_pc !== 32'h8000_0180) begin failures++; $display("FAIL b2b_next_rpc got=%h exp=80000180", redirect_pc); end
    release_redirect();
  endtask

  task automatic test_reset_in_wait();
    mem_valid = 1'b1;
    mem_flags = 8'h04;
    mem_pc    = 32'h8000_7000;
    mem_bd    = 1'b1;
    step();
    checks++; if (exc_code !== 5'h0C) begin failures++; $display("FAIL rstw_exc_code got=%h exp=0c", exc_code); end
    mem_valid = 1'b0;
    rst       = 1'b0;
    step();
    checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL rstw_redirect_valid got=%h exp=0", redirect_valid); end
    checks++; if (redirect_pc !== 32'h0) begin failures++; $display("FAIL rstw_redirect_pc got=%h exp=0", redirect_pc); end
    checks++; if (exc_code !== 5'h0) begin failures++; $display("FAIL rstw_exc_code0 got=%h exp=0", exc_code); end
    checks++; if (exc_pc !== 32'h0) begin failures++; $display("FAIL rstw_exc_pc got=%h exp=0", exc_pc); end
    checks++; if (exc_bd !== 1'b0) begin failures++; $display("FAIL rstw_exc_bd got=%h exp=0", exc_bd); end
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL rstw_flush got=%h exp=0", flush); end
    rst       = 1'b1;
    mem_valid = 1'b1;
    mem_flags = 8'h10;
    mem_bd    = 1'b0;
    mem_pc    = 32'h8000_8000;
    step();
    checks++; if (exc_valid !== 1'b1) begin failures++; $display("FAIL rstw_first_det got=%h exp=1", exc_valid); end
    checks++; if (exc_code !== 5'h09) begin failures++; $display("FAIL rstw_first_code got=%h exp=09", exc_code); end
    release_redirect();
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst            = 1'b0;
    mem_valid      = 1'b0;
    mem_pc         = 32'h0;
    mem_bd         = 1'b0;
    mem_flags      = 8'h0;
    mem_daddr      = 32'h0;
    cp0_status     = 32'h0;
    cp0_cause      = 32'h0;
    cp0_epc        = 32'h0;
    redirect_ready = 1'b0;
    #2;
    test_reset();
    test_ri_bev();
    test_load_adel_bd();
    test_fetch_adel_wrap();
    test_priority();
    test_interrupt_eret();
    test_mem_valid_low();
    test_ready_idle();
    test_back_to_back();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
